// File: rtl/dsp48a1.sv
// dsp48a1: behavioural Spartan-6 DSP48A1 slice (pre-adder, 18x18 multiplier, 48-bit post-adder)
module dsp48a1 #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT",
  parameter string RSTTYPE     = "ASYNC"
) (
  input  logic [17:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic [17:0] d,
  input  logic        carryin,
  output logic [35:0] m,
  output logic [47:0] p,
  output logic        carryout,
  output logic        carryoutf,
  input  logic        clk,
  input  logic [7:0]  opmode,
  input  logic        cea,
  input  logic        ceb,
  input  logic        cec,
  input  logic        cecarryin,
  input  logic        ced,
  input  logic        cem,
  input  logic        ceopmode,
  input  logic        cep,
  input  logic        rsta,
  input  logic        rstb,
  input  logic        rstc,
  input  logic        rstcarryin,
  input  logic        rstd,
  input  logic        rstm,
  input  logic        rstopmode,
  input  logic        rstp,
  input  logic [17:0] bcin,
  output logic [17:0] bcout,
  input  logic [47:0] pcin,
  output logic [47:0] pcout
);
  if (RSTTYPE != "ASYNC") begin : g_bad_rsttype
    $error("dsp48a1: RSTTYPE must be ASYNC");
  end
  logic [17:0] a0_q, a1_q, b0_q, b1_q, d_q;
  logic [17:0] a0, a1, b0, b1, dr, b_src, pre;
  logic [47:0] c_q, p_q, cr, x, z;
  logic [35:0] m_q, mult;
  logic [7:0]  op_q, op;
  logic [48:0] sum;
  logic        cyi_q, cyo_q, cin_src, cin;
  assign b_src = (B_INPUT == "CASCADE") ? bcin : b;
  assign a0 = (A0REG != 0) ? a0_q : a;
  assign b0 = (B0REG != 0) ? b0_q : b_src;
  assign dr = (DREG != 0) ? d_q : d;
  assign cr = (CREG != 0) ? c_q : c;
  assign op = (OPMODEREG != 0) ? op_q : opmode;
  // op[4] routes D +/- B0 into the B1 stage instead of B0 itself
  assign pre = op[4] ? (op[6] ? dr - b0 : dr + b0) : b0;
  assign a1 = (A1REG != 0) ? a1_q : a0;
  assign b1 = (B1REG != 0) ? b1_q : pre;
  assign mult = 36'(a1) * 36'(b1);
  assign m = (MREG != 0) ? m_q : mult;
  assign cin_src = (CARRYINSEL == "CARRYIN") ? carryin : op[5];
  assign cin = (CARRYINREG != 0) ? cyi_q : cin_src;
  always_comb begin
    x = op[1] ? (op[0] ? {dr[11:0], a1, b1} : p) : (op[0] ? {12'b0, m} : '0);
    z = op[3] ? (op[2] ? cr : p) : (op[2] ? pcin : '0);
    // subtract mode: sum[48] wraps to 1 exactly when a borrow occurs
    sum = op[7] ? {1'b0, z} - ({1'b0, x} + {48'b0, cin}) : {1'b0, z} + {1'b0, x} + {48'b0, cin};
  end
  assign p = (PREG != 0) ? p_q : sum[47:0];
  assign carryout = (CARRYOUTREG != 0) ? cyo_q : sum[48];
  assign carryoutf = carryout;
  assign bcout = b1;
  assign pcout = p;
  always_ff @(posedge clk or posedge rsta)
    if (rsta) begin
      a0_q <= '0;
      a1_q <= '0;
    end else if (cea) begin
      a0_q <= a;
      a1_q <= a0;
    end
  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      b0_q <= '0;
      b1_q <= '0;
    end else if (ceb) begin
      b0_q <= b_src;
      b1_q <= pre;
    end
  always_ff @(posedge clk or posedge rstc)
    if (rstc) c_q <= '0;
    else if (cec) c_q <= c;
  always_ff @(posedge clk or posedge rstd)
    if (rstd) d_q <= '0;
    else if (ced) d_q <= d;
  always_ff @(posedge clk or posedge rstm)
    if (rstm) m_q <= '0;
    else if (cem) m_q <= mult;
  always_ff @(posedge clk or posedge rstp)
    if (rstp) p_q <= '0;
    else if (cep) p_q <= sum[47:0];
  always_ff @(posedge clk or posedge rstopmode)
    if (rstopmode) op_q <= '0;
    else if (ceopmode) op_q <= opmode;
  always_ff @(posedge clk or posedge rstcarryin)
    if (rstcarryin) begin
      cyi_q <= 1'b0;
      cyo_q <= 1'b0;
    end else if (cecarryin) begin
      cyi_q <= cin_src;
      cyo_q <= sum[48];
    end
endmodule

// File: tb/tb_dsp48a1.sv
// tb_dsp48a1: directed checks of the DSP48A1 model with every stage registered
module tb_dsp48a1;
  logic [17:0] a, b, d, bcin, bcout;
  logic [47:0] c, pcin, p, pcout;
  logic [35:0] m;
  logic [7:0]  opmode;
  logic        clk, carryin, carryout, carryoutf;
  logic        cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep;
  logic        rsta, rstb, rstc, rstcarryin, rstd, rstm, rstopmode, rstp;
  int vectors = 0;
  int miscompares = 0;
  dsp48a1 #(
    .A0REG(1), .A1REG(1), .B0REG(1), .B1REG(1), .CREG(1), .DREG(1), .MREG(1), .PREG(1),
    .CARRYINREG(1), .CARRYOUTREG(1), .OPMODEREG(1),
    .CARRYINSEL("CARRYIN"), .B_INPUT("CASCADE"), .RSTTYPE("ASYNC")
  ) dut (
    .a(a), .b(b), .c(c), .d(d), .carryin(carryin), .m(m), .p(p),
    .carryout(carryout), .carryoutf(carryoutf), .clk(clk), .opmode(opmode),
    .cea(cea), .ceb(ceb), .cec(cec), .cecarryin(cecarryin), .ced(ced), .cem(cem),
    .ceopmode(ceopmode), .cep(cep), .rsta(rsta), .rstb(rstb), .rstc(rstc),
    .rstcarryin(rstcarryin), .rstd(rstd), .rstm(rstm), .rstopmode(rstopmode),
    .rstp(rstp), .bcin(bcin), .bcout(bcout), .pcin(pcin), .pcout(pcout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rst_all(input logic v);
    {rsta, rstb, rstc, rstcarryin, rstd, rstm, rstopmode, rstp} = {8{v}};
  endtask
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_m"}, {12'b0, m}, 48'd0);
    chk({tag, "_p"}, p, 48'd0);
    chk({tag, "_pcout"}, pcout, 48'd0);
    chk({tag, "_bcout"}, {30'b0, bcout}, 48'd0);
    chk({tag, "_co"}, {47'b0, carryout}, 48'd0);
    chk({tag, "_cof"}, {47'b0, carryoutf}, 48'd0);
  endtask
  initial begin
    a = '0; b = '0; c = '0; d = '0; bcin = '0; pcin = '0; opmode = '0; carryin = 1'b0;
    {cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep} = 8'hFF;
    rst_all(1'b1);
    tick(2);
    chk_zero("reset");
    rst_all(1'b0);
    a = 18'd3020; bcin = 18'd3; pcin = 48'd5123; carryin = 1'b1; opmode = 8'b0110_0101;
    tick(2);
    chk("madd_bcout", {30'b0, bcout}, 48'd3);
    tick(1);
    chk("madd_m", {12'b0, m}, 48'd9060);
    tick(1);
    chk("madd_p", p, 48'd14184);
    chk("madd_pcout", pcout, 48'd14184);
    chk("madd_co", {47'b0, carryout}, 48'd0);
    d = 18'd100; bcin = 18'd30; a = 18'd5; carryin = 1'b0; opmode = 8'b0101_0001;
    tick(2);
    chk("presub_bcout", {30'b0, bcout}, 48'd70);
    tick(1);
    chk("presub_m", {12'b0, m}, 48'd350);
    tick(1);
    chk("presub_p", p, 48'd350);
    d = 18'd0; bcin = 18'd1; opmode = 8'b0101_0000;
    tick(2);
    chk("prewrap_bcout", {30'b0, bcout}, 48'h3FFFF);
    tick(1);
    chk("prewrap_m", {12'b0, m}, 48'h13FFFB);
    c = 48'd1000; d = 18'd0; a = 18'd0; bcin = 18'd10; opmode = 8'b1000_1111; carryin = 1'b0;
    tick(4);
    chk("csub_p", p, 48'd990);
    chk("csub_co", {47'b0, carryout}, 48'd0);
    c = 48'd5;
    tick(4);
    chk("cborrow_p", p, 48'hFFFF_FFFF_FFFB);
    chk("cborrow_co", {47'b0, carryout}, 48'd1);
    chk("cborrow_cof", {47'b0, carryoutf}, 48'd1);
    a = 18'd2; bcin = 18'd3; opmode = 8'b0000_1001; carryin = 1'b0; rstp = 1'b1;
    tick(3);
    chk("acc_m", {12'b0, m}, 48'd6);
    chk("acc_p0", p, 48'd0);
    rstp = 1'b0;
    tick(1);
    chk("acc_p6", p, 48'd6);
    tick(1);
    chk("acc_p12", p, 48'd12);
    tick(1);
    chk("acc_p18", p, 48'd18);
    #2 rstp = 1'b1;
    #1;
    chk("arst_p", p, 48'd0);
    chk("arst_pcout", pcout, 48'd0);
    chk("arst_m_kept", {12'b0, m}, 48'd6);
    #1 rstp = 1'b0;
    tick(1);
    chk("arst_resume", p, 48'd6);
    cep = 1'b0;
    tick(2);
    chk("hold_p", p, 48'd6);
    cep = 1'b1;
    tick(1);
    chk("hold_resume", p, 48'd12);
    rst_all(1'b1);
    #1;
    chk_zero("allrst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
